// File: rtl/snoop_mesi_array.sv
// snoop_mesi_array: bus-side MESI snoop controller for a direct-mapped cache.
// Snoop results are registered with one-cycle latency; a Modified hit holds off the bus until the write-back is acked.
module snoop_mesi_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          snoopValid,
  input  logic [1:0]                    snoopOp,
  input  logic [ADDR_WIDTH-1:0]         snoopAddr,
  output logic                          snoopReady,
  output logic                          snoopDone,
  output logic                          snoopHit,
  output logic                          sharedOut,
  output logic                          writeBack,
  output logic                          abortMemoryAccess,
  input  logic                          writeBackAck,
  input  logic                          localWrite,
  input  logic [ADDR_WIDTH-1:0]         localAddr,
  input  logic [1:0]                    localState,
  output logic                          localStall,
  input  logic [INDEX_WIDTH-1:0]        readIndex,
  output logic [1:0]                    readState,
  output logic [ADDR_WIDTH-INDEX_WIDTH-1:0] readTag
);
  localparam int TW = ADDR_WIDTH - INDEX_WIDTH;
  localparam int LINES = 2 ** INDEX_WIDTH;
  localparam logic [1:0] I = 2'b00, S = 2'b01, M = 2'b10;
  typedef enum logic {IDLE, WB} ctrlT;
  ctrlT ctrl;
  logic [1:0] lineState [LINES];
  logic [TW-1:0] lineTag [LINES];
  logic [INDEX_WIDTH-1:0] sIdx, lIdx;
  logic [TW-1:0] sTag;
  logic accept, hit;
  assign sIdx = snoopAddr[INDEX_WIDTH-1:0];
  assign sTag = snoopAddr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign lIdx = localAddr[INDEX_WIDTH-1:0];
  assign accept = snoopValid && snoopReady;
  assign hit = accept && snoopOp != 2'b00 && lineState[sIdx] != I && lineTag[sIdx] == sTag;
  // An accepted snoop owns its line this cycle; a colliding local write is dropped
  assign localStall = localWrite && accept && lIdx == sIdx;
  assign readState = lineState[readIndex];
  assign readTag = lineTag[readIndex];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ctrl <= IDLE;
      snoopReady <= 1'b1;
      snoopDone <= 1'b0;
      snoopHit <= 1'b0;
      sharedOut <= 1'b0;
      writeBack <= 1'b0;
      abortMemoryAccess <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        lineState[i] <= I;
        lineTag[i] <= '0;
      end
    end else begin
      snoopDone <= accept;
      snoopHit <= hit;
      sharedOut <= hit && snoopOp == 2'b01;
      if (localWrite && !localStall) begin
        lineState[lIdx] <= localState;
        lineTag[lIdx] <= localAddr[ADDR_WIDTH-1:INDEX_WIDTH];
      end
      if (hit) lineState[sIdx] <= snoopOp == 2'b01 ? S : I;
      if (hit && lineState[sIdx] == M) begin
        ctrl <= WB;
        snoopReady <= 1'b0;
        writeBack <= 1'b1;
        abortMemoryAccess <= 1'b1;
      end else if (ctrl == WB && writeBackAck) begin
        ctrl <= IDLE;
        snoopReady <= 1'b1;
        writeBack <= 1'b0;
        abortMemoryAccess <= 1'b0;
      end
    end
endmodule

// File: tb/tb_snoop_mesi_array.sv
// tb_snoop_mesi_array: directed plan plus random traffic against a line-level MESI reference model.
module tb_snoop_mesi_array;
  logic clock = 0, reset = 1;
  logic snoopValid = 0, writeBackAck = 0, localWrite = 0;
  logic [1:0] snoopOp = 0, localState = 0, readIndex = 0;
  logic [7:0] snoopAddr = 0, localAddr = 0;
  logic snoopReady, snoopDone, snoopHit, sharedOut, writeBack, abortMemoryAccess, localStall;
  logic [1:0] readState;
  logic [5:0] readTag;
  int compared = 0, mismatched = 0;
  int mState [4];
  int mTag [4];
  bit mWb;

  snoop_mesi_array dut (
    .clock(clock), .reset(reset), .snoopValid(snoopValid), .snoopOp(snoopOp), .snoopAddr(snoopAddr),
    .snoopReady(snoopReady), .snoopDone(snoopDone), .snoopHit(snoopHit), .sharedOut(sharedOut),
    .writeBack(writeBack), .abortMemoryAccess(abortMemoryAccess), .writeBackAck(writeBackAck),
    .localWrite(localWrite), .localAddr(localAddr), .localState(localState), .localStall(localStall),
    .readIndex(readIndex), .readState(readState), .readTag(readTag)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, int obs, int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    foreach (mState[i]) begin
      mState[i] = 0;
      mTag[i] = 0;
    end
    mWb = 0;
  endtask

  task automatic drive(bit v, int op, int addr, bit lw, int laddr, int ls, bit ack);
    snoopValid = v;
    snoopOp = 2'(op);
    snoopAddr = 8'(addr);
    localWrite = lw;
    localAddr = 8'(laddr);
    localState = 2'(ls);
    writeBackAck = ack;
    readIndex = 2'($urandom_range(0, 3));
  endtask

  // One clock: predict from the rules, check the combinational stall, then all registered outputs.
  task automatic cycle();
    int sIdx, lIdx, sTag;
    bit acc, hitE, stall, wasM;
    sIdx = int'(snoopAddr) % 4;
    sTag = int'(snoopAddr) / 4;
    lIdx = int'(localAddr) % 4;
    acc = snoopValid && !mWb;
    hitE = acc && snoopOp != 0 && mState[sIdx] != 0 && mTag[sIdx] == sTag;
    stall = localWrite && acc && lIdx == sIdx;
    #1 chk("localStall", localStall, stall);
    @(posedge clock);
    #1;
    wasM = hitE && mState[sIdx] == 2;
    if (localWrite && !stall) begin
      mState[lIdx] = localState;
      mTag[lIdx] = int'(localAddr) / 4;
    end
    if (hitE) mState[sIdx] = snoopOp == 1 ? 1 : 0;
    mWb = mWb ? !writeBackAck : wasM;
    chk("snoopDone", snoopDone, acc);
    chk("snoopHit", snoopHit, hitE);
    chk("sharedOut", sharedOut, hitE && snoopOp == 1);
    chk("writeBack", writeBack, mWb);
    chk("abortMemoryAccess", abortMemoryAccess, mWb);
    chk("snoopReady", snoopReady, !mWb);
    chk("readState", readState, mState[readIndex]);
    chk("readTag", readTag, mTag[readIndex]);
  endtask

  task automatic sweepInvalid(string tag);
    for (int i = 0; i < 4; i++) begin
      readIndex = 2'(i);
      #1;
      chk({tag, "_state"}, readState, 0);
      chk({tag, "_tag"}, readTag, 0);
    end
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    sweepInvalid("reset");
    chk("reset_ready", snoopReady, 1);
    chk("reset_wb", writeBack, 0);
    chk("reset_done", snoopDone, 0);

    drive(0, 0, 0, 1, 'h25, 3, 0); cycle();
    drive(1, 1, 'h25, 0, 0, 0, 0); readIndex = 1; cycle();
    chk("rm_hit", snoopHit, 1);
    chk("rm_shared", sharedOut, 1);
    chk("rm_wb", writeBack, 0);
    chk("rm_state", readState, 1);

    drive(0, 0, 0, 1, 'h26, 2, 0); cycle();
    drive(1, 2, 'h26, 0, 0, 0, 0); cycle();
    chk("wm_wb", writeBack, 1);
    chk("wm_abort", abortMemoryAccess, 1);
    chk("wm_ready", snoopReady, 0);
    repeat (3) begin
      drive(1, 1, 'h25, 0, 0, 0, 0); cycle();
      chk("wm_hold", writeBack, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    chk("wm_drop", writeBack, 0);
    chk("wm_ready2", snoopReady, 1);
    readIndex = 2;
    #1 chk("wm_state", readState, 0);

    drive(1, 3, 'h65, 0, 0, 0, 0); readIndex = 1; cycle();
    chk("inv_miss", snoopHit, 0);
    chk("inv_state", readState, 1);

    drive(0, 0, 0, 1, 'h27, 3, 0); cycle();
    drive(1, 2, 'h27, 1, 'h27, 1, 0); readIndex = 3; cycle();
    chk("conf_state", readState, 0);
    drive(0, 0, 0, 1, 'h27, 3, 0); cycle();
    drive(1, 2, 'h27, 1, 'h24, 1, 0); readIndex = 0; cycle();
    chk("par_state0", readState, 1);
    chk("par_tag0", readTag, 9);
    readIndex = 3;
    #1 chk("par_state3", readState, 0);

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3),
            ($urandom_range(0, 2) << 2) | $urandom_range(0, 3),
            $urandom_range(0, 2) == 0, ($urandom_range(0, 2) << 2) | $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 2) == 0);
      cycle();
    end

    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 1, 'h04, 2, 0); cycle();
    drive(1, 2, 'h04, 0, 0, 0, 0); cycle();
    chk("rst_pre_wb", writeBack, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #3 reset = 1;
    #1;
    chk("rst_wb", writeBack, 0);
    chk("rst_abort", abortMemoryAccess, 0);
    chk("rst_ready", snoopReady, 1);
    sweepInvalid("rst");
    modelReset();
    @(posedge clock);
    #1 reset = 0;
    drive(1, 1, 'h04, 0, 0, 0, 0); cycle();
    chk("rst_after_hit", snoopHit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
